// File: rtl/nx_xrfb_fifo_ctrl_pkg.sv
// nx_xrfb_fifo_ctrl_pkg: XRFB primitive geometries and the parameter legality check
// shared by the FIFO controller and the memory-mapping helpers.
package nx_xrfb_fifo_ctrl_pkg;
  localparam int XRFB_64X18_ADDR_BITS = 6;
  localparam int XRFB_64X18_WIDTH = 18;
  localparam int XRFB_32X36_ADDR_BITS = 5;
  localparam int XRFB_32X36_WIDTH = 36;
  // Native data width of the XRFB addressed with addr_bits bits, 0 when no primitive matches.
  function automatic int xrfb_native_width(input int addr_bits);
    return addr_bits == XRFB_64X18_ADDR_BITS ? XRFB_64X18_WIDTH :
           addr_bits == XRFB_32X36_ADDR_BITS ? XRFB_32X36_WIDTH : 0;
  endfunction
  function automatic bit xrfb_geometry_ok(input int width, input int addr_bits);
    return xrfb_native_width(addr_bits) != 0 && width >= 1 && width <= xrfb_native_width(addr_bits);
  endfunction
endpackage

// File: rtl/nx_xrfb_fifo_ctrl.sv
// nx_xrfb_fifo_ctrl: turns one NX_XRFB register file into a valid/ready FIFO,
// managing wrap-bit pointers, full/empty flow control and a registered output stage.
module nx_xrfb_fifo_ctrl
  import nx_xrfb_fifo_ctrl_pkg::*;
#(
  parameter int WIDTH = 18,
  parameter int ADDR_BITS = 6
) (
  input  logic                 clock,
  input  logic                 async_reset,
  input  logic [WIDTH-1:0]     s_data,
  input  logic                 s_valid,
  output logic                 s_ready,
  output logic [WIDTH-1:0]     m_data,
  output logic                 m_valid,
  input  logic                 m_ready,
  output logic [WIDTH-1:0]     xrfb_i,
  output logic [ADDR_BITS-1:0] xrfb_wa,
  output logic                 xrfb_we,
  output logic                 xrfb_wea,
  output logic [ADDR_BITS-1:0] xrfb_ra,
  input  logic [WIDTH-1:0]     xrfb_o,
  output logic [ADDR_BITS:0]   level
);
  if (!xrfb_geometry_ok(WIDTH, ADDR_BITS)) begin : g_bad_geometry
    $error("nx_xrfb_fifo_ctrl: WIDTH=%0d ADDR_BITS=%0d matches no XRFB primitive", WIDTH, ADDR_BITS);
  end
  logic [ADDR_BITS:0] r_wr_ptr;
  logic [ADDR_BITS:0] r_rd_ptr;
  logic [WIDTH-1:0]   r_m_data;
  logic               r_m_valid;
  logic [ADDR_BITS:0] w_mem_cnt;
  logic               w_mem_empty;
  logic               w_mem_full;
  logic               w_push;
  logic               w_load;
  assign w_mem_cnt   = r_wr_ptr - r_rd_ptr;
  assign w_mem_empty = w_mem_cnt == '0;
  // Occupancy never exceeds 2^ADDR_BITS, so its top bit alone marks full.
  assign w_mem_full  = w_mem_cnt[ADDR_BITS];
  assign s_ready     = !w_mem_full && !async_reset;
  assign w_push      = s_valid && s_ready;
  assign w_load      = !w_mem_empty && (!r_m_valid || m_ready);
  assign xrfb_i      = s_data;
  assign xrfb_wa     = r_wr_ptr[ADDR_BITS-1:0];
  assign xrfb_we     = w_push;
  assign xrfb_wea    = 1'b1;
  assign xrfb_ra     = r_rd_ptr[ADDR_BITS-1:0];
  assign m_data      = r_m_data;
  assign m_valid     = r_m_valid;
  assign level       = w_mem_cnt + {{ADDR_BITS{1'b0}}, r_m_valid};
  // Pointers only meet when the memory is empty, so a load never reads the slot being written.
  always_ff @(posedge clock or posedge async_reset) begin
    if (async_reset) begin
      r_wr_ptr  <= '0;
      r_rd_ptr  <= '0;
      r_m_data  <= '0;
      r_m_valid <= 1'b0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_load) begin
        r_rd_ptr  <= r_rd_ptr + 1'b1;
        r_m_data  <= xrfb_o;
        r_m_valid <= 1'b1;
      end else if (r_m_valid && m_ready) begin
        r_m_valid <= 1'b0;
      end
    end
  end
endmodule

// File: tb/tb_nx_xrfb_fifo_ctrl.sv
// tb_nx_xrfb_fifo_ctrl: drives the controller against behavioural XRFB models (64x18 and 32x36)
// and checks it with a vector table, hand sequences and a queue-based reference model.
module tb_nx_xrfb_fifo_ctrl;
  localparam int W = 18, A = 6, D = 64;
  localparam int W2 = 36, A2 = 5, D2 = 32;
  logic clock = 1'b0;
  logic async_reset = 1'b1;
  always #5 clock = ~clock;

  logic [W-1:0] s_data, m_data, xrfb_i, xrfb_o;
  logic s_valid, s_ready, m_valid, m_ready, xrfb_we, xrfb_wea;
  logic [A-1:0] xrfb_wa, xrfb_ra;
  logic [A:0] level;
  logic [W-1:0] mem [D];

  nx_xrfb_fifo_ctrl #(.WIDTH(W), .ADDR_BITS(A)) dut (
    .clock(clock), .async_reset(async_reset),
    .s_data(s_data), .s_valid(s_valid), .s_ready(s_ready),
    .m_data(m_data), .m_valid(m_valid), .m_ready(m_ready),
    .xrfb_i(xrfb_i), .xrfb_wa(xrfb_wa), .xrfb_we(xrfb_we), .xrfb_wea(xrfb_wea),
    .xrfb_ra(xrfb_ra), .xrfb_o(xrfb_o), .level(level)
  );
  always @(posedge clock) if (xrfb_we) mem[xrfb_wa] <= xrfb_i;
  assign xrfb_o = mem[xrfb_ra];

  logic [W2-1:0] b_s_data, b_m_data, b_xrfb_i, b_xrfb_o;
  logic b_s_valid, b_s_ready, b_m_valid, b_m_ready, b_xrfb_we, b_xrfb_wea;
  logic [A2-1:0] b_xrfb_wa, b_xrfb_ra;
  logic [A2:0] b_level;
  logic [W2-1:0] b_mem [D2];

  nx_xrfb_fifo_ctrl #(.WIDTH(W2), .ADDR_BITS(A2)) dut_b (
    .clock(clock), .async_reset(async_reset),
    .s_data(b_s_data), .s_valid(b_s_valid), .s_ready(b_s_ready),
    .m_data(b_m_data), .m_valid(b_m_valid), .m_ready(b_m_ready),
    .xrfb_i(b_xrfb_i), .xrfb_wa(b_xrfb_wa), .xrfb_we(b_xrfb_we), .xrfb_wea(b_xrfb_wea),
    .xrfb_ra(b_xrfb_ra), .xrfb_o(b_xrfb_o), .level(b_level)
  );
  always @(posedge clock) if (b_xrfb_we) b_mem[b_xrfb_wa] <= b_xrfb_i;
  assign b_xrfb_o = b_mem[b_xrfb_ra];

  int n_vec = 0;
  int n_err = 0;

  task automatic chk(input string nm, input logic [35:0] act, input logic [35:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Reference: words held in memory as a queue plus the output register.
  logic [W-1:0] q[$];
  bit ov;
  logic [W-1:0] od;

  task automatic model_reset();
    q.delete();
    ov = 1'b0;
    od = '0;
  endtask

  // Called at posedge+1; applies one cycle of inputs and checks the model before and after the edge.
  task automatic cycle(input bit sv, input logic [W-1:0] sd, input bit mr);
    bit exp_rdy, push, pop, load;
    s_valid = sv;
    s_data = sd;
    m_ready = mr;
    #1;
    exp_rdy = q.size() < D;
    chk("s_ready", 36'(s_ready), 36'(exp_rdy));
    chk("xrfb_we", 36'(xrfb_we), 36'(sv && exp_rdy));
    @(posedge clock);
    push = sv && exp_rdy;
    pop = ov && mr;
    load = q.size() != 0 && (!ov || mr);
    if (pop) ov = 1'b0;
    if (load) begin
      od = q.pop_front();
      ov = 1'b1;
    end
    if (push) q.push_back(sd);
    #1;
    chk("m_valid", 36'(m_valid), 36'(ov));
    chk("m_data", 36'(m_data), 36'(od));
    chk("level", 36'(level), 36'(q.size() + int'(ov)));
  endtask

  task automatic do_reset();
    async_reset = 1'b1;
    s_valid = 1'b0;
    m_ready = 1'b0;
    b_s_valid = 1'b0;
    b_m_ready = 1'b0;
    #2;
    async_reset = 1'b0;
    @(posedge clock);
    #1;
    model_reset();
  endtask

  typedef struct {
    bit sv;
    logic [W-1:0] sd;
    bit mr;
    bit e_rdy;
    bit e_mv;
    logic [W-1:0] e_md;
    logic [A:0] e_lvl;
  } vec_t;
  vec_t tv[9];

  initial begin
    int exp_word;
    bit found;
    tv[0] = '{1'b1, 18'h00001, 1'b1, 1'b1, 1'b0, 18'h00000, 7'd1};
    tv[1] = '{1'b0, 18'h00000, 1'b1, 1'b1, 1'b1, 18'h00001, 7'd1};
    tv[2] = '{1'b0, 18'h00000, 1'b1, 1'b1, 1'b0, 18'h00001, 7'd0};
    tv[3] = '{1'b1, 18'h2AAAA, 1'b0, 1'b1, 1'b0, 18'h00001, 7'd1};
    tv[4] = '{1'b1, 18'h15555, 1'b0, 1'b1, 1'b1, 18'h2AAAA, 7'd2};
    tv[5] = '{1'b0, 18'h00000, 1'b0, 1'b1, 1'b1, 18'h2AAAA, 7'd2};
    tv[6] = '{1'b0, 18'h00000, 1'b1, 1'b1, 1'b1, 18'h15555, 7'd1};
    tv[7] = '{1'b0, 18'h00000, 1'b1, 1'b1, 1'b0, 18'h15555, 7'd0};
    tv[8] = '{1'b1, 18'h3FFFF, 1'b1, 1'b1, 1'b0, 18'h15555, 7'd1};
    s_valid = 1'b0; s_data = '0; m_ready = 1'b0;
    b_s_valid = 1'b0; b_s_data = '0; b_m_ready = 1'b0;
    #1 s_valid = 1'b1;
    #1;
    chk("rst_s_ready", 36'(s_ready), 36'd0);
    chk("rst_xrfb_we", 36'(xrfb_we), 36'd0);
    chk("rst_m_valid", 36'(m_valid), 36'd0);
    chk("rst_m_data", 36'(m_data), 36'd0);
    chk("rst_level", 36'(level), 36'd0);
    s_valid = 1'b0;
    @(posedge clock);
    #1 async_reset = 1'b0;

    for (int i = 0; i < 9; i++) begin
      s_valid = tv[i].sv;
      s_data = tv[i].sd;
      m_ready = tv[i].mr;
      @(posedge clock);
      #1;
      chk($sformatf("tv%0d_s_ready", i), 36'(s_ready), 36'(tv[i].e_rdy));
      chk($sformatf("tv%0d_m_valid", i), 36'(m_valid), 36'(tv[i].e_mv));
      chk($sformatf("tv%0d_m_data", i), 36'(m_data), 36'(tv[i].e_md));
      chk($sformatf("tv%0d_level", i), 36'(level), 36'(tv[i].e_lvl));
    end

    do_reset();
    for (int i = 0; i <= D; i++) cycle(1'b1, W'(i), 1'b0);
    chk("full_level", 36'(level), 36'd65);
    chk("full_s_ready", 36'(s_ready), 36'd0);
    exp_word = 0;
    for (int i = 0; i <= D; i++) begin
      chk("drain_valid", 36'(m_valid), 36'd1);
      chk("drain_order", 36'(m_data), 36'(exp_word));
      exp_word++;
      cycle(1'b0, '0, 1'b1);
      if (i == 0) chk("s_ready_after_first_pop", 36'(s_ready), 36'd1);
    end
    chk("drain_empty_level", 36'(level), 36'd0);

    for (int i = 0; i < 200; i++) begin
      cycle(1'b1, W'(i), 1'b1);
      if (i >= 1) begin
        chk("stream_no_gap", 36'(m_valid), 36'd1);
        chk("stream_level", 36'(level >= 7'd1 && level <= 7'd2), 36'd1);
      end
    end
    for (int i = 0; i < 3; i++) cycle(1'b0, '0, 1'b1);

    for (int i = 0; i < 10000; i++)
      cycle(1'($urandom_range(0, 1)), W'($urandom), 1'($urandom_range(0, 1)));
    for (int i = 0; i < D + 2; i++) cycle(1'b0, '0, 1'b1);

    do_reset();
    for (int i = 0; i < 10; i++) cycle(1'b1, W'(100 + i), 1'b0);
    chk("pre_reset_level", 36'(level), 36'd10);
    #2 async_reset = 1'b1;
    #1;
    chk("async_m_valid", 36'(m_valid), 36'd0);
    chk("async_s_ready", 36'(s_ready), 36'd0);
    chk("async_level", 36'(level), 36'd0);
    s_valid = 1'b0;
    @(posedge clock);
    #3 async_reset = 1'b0;
    @(posedge clock);
    #1;
    model_reset();
    cycle(1'b1, 18'h3FFFF, 1'b1);
    found = 1'b0;
    for (int k = 0; k < 6; k++) begin
      if (!found && m_valid) begin
        chk("post_reset_first", 36'(m_data), 36'h3FFFF);
        found = 1'b1;
      end
      cycle(1'b0, '0, 1'b1);
    end
    chk("post_reset_seen", 36'(found), 36'd1);

    do_reset();
    for (int i = 0; i <= D2; i++) begin
      b_s_valid = 1'b1;
      b_s_data = 36'hA_5000_0000 | 36'(i);
      #1;
      chk("b_fill_ready", 36'(b_s_ready), 36'd1);
      @(posedge clock);
      #1;
    end
    b_s_valid = 1'b0;
    chk("b_full_level", 36'(b_level), 36'd33);
    chk("b_full_s_ready", 36'(b_s_ready), 36'd0);
    b_m_ready = 1'b1;
    for (int i = 0; i <= D2; i++) begin
      chk("b_drain_valid", 36'(b_m_valid), 36'd1);
      chk("b_drain_order", b_m_data, 36'hA_5000_0000 | 36'(i));
      @(posedge clock);
      #1;
    end
    chk("b_empty_valid", 36'(b_m_valid), 36'd0);
    chk("b_empty_level", 36'(b_level), 36'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
